prga_sync_fifo: RTL and testbench

Single-clock synchronous FIFO with a compile-time choice of read protocol. In non-lookahead mode, `rd` fetches the head word, which appears on `dout` one cycle later. In lookahead (first-word-fall-through) mode, `dout` already shows the head word whenever `empty` is low, and `rd` pops it. It serves as the generic buffering primitive between producer/consumer blocks in the PRGA fabric and controller logic.

---
 rtl/prga_sync_fifo.sv | 121 ++++++++++++
 tb/tb_prga_sync_fifo.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prga_sync_fifo.sv
// prga_sync_fifo: single-clock synchronous FIFO.
// LOOKAHEAD=0: rd fetches the head word into dout one cycle later.
// LOOKAHEAD=1: first-word-fall-through; dout shows the head whenever empty is low, rd pops it.
// Optional macro PRGA_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module prga_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned LOOKAHEAD  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  full,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  empty,
  input  logic                  rd,
`ifdef PRGA_FIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PtrOne = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DEPTH_LOG2:0]   wptr_q, rptr_q;
  logic [DATA_WIDTH-1:0] core_dout_q;
  logic                  empty_core;
  logic                  wr_accept;
  logic                  core_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_core = (wptr_q == rptr_q);
  assign full       = (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]) &&
                      (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]);
  assign wr_accept  = wr && !full;

  // Storage array write; no reset needed since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem_q[wptr_q[DEPTH_LOG2-1:0]] <= din;
    end
  end

  // Pointer advance; simultaneous accepted write and read both move.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_accept) wptr_q <= wptr_q + PtrOne;
      if (core_rd)   rptr_q <= rptr_q + PtrOne;
    end
  end

  // Registered core read port: head word appears the cycle after core_rd.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_dout_q <= '0;
    end else if (core_rd) begin
      core_dout_q <= mem_q[rptr_q[DEPTH_LOG2-1:0]];
    end
  end

  if (LOOKAHEAD == 0) begin : g_std
    assign core_rd = rd && !empty_core;
    assign empty   = empty_core;
    assign dout    = core_dout_q;
  end else begin : g_lookahead
    logic                  la_valid_q;
    logic                  pend_q;   // core_dout_q holds a fetched word not yet in la_q
    logic [DATA_WIDTH-1:0] la_q;
    logic                  pop;
    logic                  la_load;

    assign pop     = rd && la_valid_q;
    // Refill whenever the lookahead slot is free or being vacated this cycle.
    assign core_rd = !empty_core && (!la_valid_q || pop);
    assign la_load = pend_q && (!la_valid_q || pop);

    // Lookahead register and in-flight tracking for the core output word.
    always_ff @(posedge clk) begin
      if (rst) begin
        la_valid_q <= 1'b0;
        pend_q     <= 1'b0;
        la_q       <= '0;
      end else begin
        if (core_rd) begin
          pend_q <= 1'b1;
        end else if (la_load) begin
          pend_q <= 1'b0;
        end
        if (la_load) begin
          la_q       <= core_dout_q;
          la_valid_q <= 1'b1;
        end else if (pop) begin
          la_valid_q <= 1'b0;
        end
      end
    end

    assign empty = !la_valid_q;
    assign dout  = la_q;
  end

`ifdef PRGA_FIFO_ERR_FLAGS_EN
  // Sticky error flags for requests made against full/empty; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full)  overflow  <= 1'b1;
      if (rd && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_prga_sync_fifo.sv
// Directed bench for prga_sync_fifo: one non-lookahead and one lookahead instance,
// both DEPTH_LOG2=2, exercised in a linear sequence from a single initial block.
module tb_prga_sync_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr0, rd0, wr1, rd1;
  logic [31:0] din0, din1;
  logic        full0, empty0, full1, empty1;
  logic [31:0] dout0, dout1;
`ifdef PRGA_FIFO_ERR_FLAGS_EN
  logic        ovf0, unf0, ovf1, unf1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  prga_sync_fifo #(
    .DATA_WIDTH(32),
    .DEPTH_LOG2(2),
    .LOOKAHEAD (0)
  ) u_std (
    .clk      (clk),
    .rst      (rst),
    .full     (full0),
    .wr       (wr0),
    .din      (din0),
    .empty    (empty0),
    .rd       (rd0),
`ifdef PRGA_FIFO_ERR_FLAGS_EN
    .overflow (ovf0),
    .underflow(unf0),
`endif
    .dout     (dout0)
  );

  prga_sync_fifo #(
    .DATA_WIDTH(32),
    .DEPTH_LOG2(2),
    .LOOKAHEAD (1)
  ) u_la (
    .clk      (clk),
    .rst      (rst),
    .full     (full1),
    .wr       (wr1),
    .din      (din1),
    .empty    (empty1),
    .rd       (rd1),
`ifdef PRGA_FIFO_ERR_FLAGS_EN
    .overflow (ovf1),
    .underflow(unf1),
`endif
    .dout     (dout1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    wr0 = 1'b0; rd0 = 1'b0; din0 = '0;
    wr1 = 1'b0; rd1 = 1'b0; din1 = '0;
    step();
    step();
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_empty0", 32'(empty0), 32'd1);
      check("idle_full0",  32'(full0),  32'd0);
      check("idle_dout0",  dout0,       32'd0);
      check("idle_empty1", 32'(empty1), 32'd1);
      check("idle_full1",  32'(full1),  32'd0);
      check("idle_dout1",  dout1,       32'd0);
    end
`ifdef PRGA_FIFO_ERR_FLAGS_EN
    check("idle_ovf0", 32'(ovf0), 32'd0);
    check("idle_unf0", 32'(unf0), 32'd0);
`endif

    // Non-lookahead: three writes then three held reads
    wr0 = 1'b1; din0 = 32'h11;
    step();
    check("a_empty_after_wr", 32'(empty0), 32'd0);
    din0 = 32'h22;
    step();
    din0 = 32'h33;
    step();
    wr0 = 1'b0; rd0 = 1'b1;
    step();
    check("a_rd1", dout0, 32'h11);
    check("a_rd1_empty", 32'(empty0), 32'd0);
    step();
    check("a_rd2", dout0, 32'h22);
    step();
    check("a_rd3", dout0, 32'h33);
    check("a_empty_after_rd3", 32'(empty0), 32'd1);
    rd0 = 1'b0;
    step();
    check("a_dout_hold", dout0, 32'h33);

    // Lookahead: single word latency and pop
    wr1 = 1'b1; din1 = 32'hA5;
    step();
    wr1 = 1'b0;
    check("b_empty_n", 32'(empty1), 32'd1);
    step();
    check("b_empty_n1", 32'(empty1), 32'd1);
    step();
    check("b_empty_n2", 32'(empty1), 32'd0);
    check("b_dout_n2",  dout1,       32'hA5);
    step();
    check("b_dout_stable", dout1, 32'hA5);
    rd1 = 1'b1;
    step();
    rd1 = 1'b0;
    check("b_empty_after_pop", 32'(empty1), 32'd1);

    // Non-lookahead overflow: write 0..5, only 0..3 stored
    for (int i = 0; i < 6; i++) begin
      wr0 = 1'b1; din0 = 32'(i);
      step();
      check("c_full", 32'(full0), (i >= 3) ? 32'd1 : 32'd0);
    end
    wr0 = 1'b0;
`ifdef PRGA_FIFO_ERR_FLAGS_EN
    check("c_overflow", 32'(ovf0), 32'd1);
    check("c_underflow_clear", 32'(unf0), 32'd0);
`endif
    // Write while full is dropped even with a concurrent accepted read
    wr0 = 1'b1; din0 = 32'h99; rd0 = 1'b1;
    step();
    wr0 = 1'b0;
    check("c_rd0", dout0, 32'd0);
    check("c_full_drop", 32'(full0), 32'd0);
    for (int i = 1; i < 4; i++) begin
      step();
      check("c_rd", dout0, 32'(i));
    end
    check("c_empty_drained", 32'(empty0), 32'd1);
    // Read while empty is dropped even with a concurrent accepted write
    wr0 = 1'b1; din0 = 32'h44;
    step();
    wr0 = 1'b0;
    check("c_rd_empty_ignored", dout0, 32'd3);
    check("c_wr_taken", 32'(empty0), 32'd0);
`ifdef PRGA_FIFO_ERR_FLAGS_EN
    check("c_underflow", 32'(unf0), 32'd1);
`endif
    step();
    rd0 = 1'b0;
    check("c_rd44", dout0, 32'h44);
    check("c_empty_44", 32'(empty0), 32'd1);

    // Non-lookahead: concurrent write/read on half-full FIFO, across pointer wrap
    wr0 = 1'b1; din0 = 32'd100;
    step();
    din0 = 32'd101;
    step();
    for (int i = 0; i < 20; i++) begin
      wr0 = 1'b1; rd0 = 1'b1; din0 = 32'(102 + i);
      step();
      check("d_stream", dout0, 32'(100 + i));
      check("d_empty", 32'(empty0), 32'd0);
      check("d_full",  32'(full0),  32'd0);
    end
    wr0 = 1'b0;
    step();
    check("d_tail0", dout0, 32'd120);
    step();
    check("d_tail1", dout0, 32'd121);
    check("d_tail_empty", 32'(empty0), 32'd1);
    rd0 = 1'b0;

    // Lookahead: prefill then back-to-back pops with concurrent writes
    wr1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din1 = 32'(200 + i);
      step();
    end
    wr1 = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i < 10) begin
        wr1 = 1'b1; din1 = 32'(203 + i);
      end else begin
        wr1 = 1'b0;
      end
      rd1 = 1'b1;
      check("e_head", dout1, 32'(200 + i));
      check("e_nonempty", 32'(empty1), 32'd0);
      step();
    end
    rd1 = 1'b0; wr1 = 1'b0;
    check("e_drained", 32'(empty1), 32'd1);
`ifdef PRGA_FIFO_ERR_FLAGS_EN
    check("e_underflow1", 32'(unf1), 32'd0);
`endif

    // Mid-operation reset with 3 words stored in each instance
    wr0 = 1'b1; wr1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din0 = 32'(32'hD0 + i); din1 = 32'(32'hD0 + i);
      step();
    end
    check("f_pre_empty1", 32'(empty1), 32'd0);
    rst = 1'b1; rd0 = 1'b1; rd1 = 1'b1; din0 = 32'hBB; din1 = 32'hBB;
    step();
    rst = 1'b0; wr0 = 1'b0; wr1 = 1'b0; rd0 = 1'b0; rd1 = 1'b0;
    check("f_empty0", 32'(empty0), 32'd1);
    check("f_dout0",  dout0,       32'd0);
    check("f_full0",  32'(full0),  32'd0);
    check("f_empty1", 32'(empty1), 32'd1);
    check("f_dout1",  dout1,       32'd0);
`ifdef PRGA_FIFO_ERR_FLAGS_EN
    check("f_ovf0_clr", 32'(ovf0), 32'd0);
    check("f_unf0_clr", 32'(unf0), 32'd0);
`endif
    wr0 = 1'b1; din0 = 32'hE7; wr1 = 1'b1; din1 = 32'hE7;
    step();
    wr0 = 1'b0; wr1 = 1'b0; rd0 = 1'b1;
    check("f_empty1_n", 32'(empty1), 32'd1);
    step();
    rd0 = 1'b0;
    check("f_post_dout0", dout0, 32'hE7);
    check("f_post_empty0", 32'(empty0), 32'd1);
    check("f_empty1_n1", 32'(empty1), 32'd1);
    step();
    check("f_post_empty1", 32'(empty1), 32'd0);
    check("f_post_dout1", dout1, 32'hE7);
    rd1 = 1'b1;
    step();
    rd1 = 1'b0;
    check("f_final_empty1", 32'(empty1), 32'd1);
    check("f_final_dout0", dout0, 32'hE7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
